ir_transmitter: RTL and testbench

IR_TRANSMITTER -- requirements
Module: ir_transmitter

---
 rtl/ir_transmitter.sv | 158 +++++++++++++++
 tb/tb_ir_transmitter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_transmitter.sv
// rtl/ir_transmitter.sv - periodic IR command packet transmitter
//
// Purpose: every PACKET_PERIOD clocks, sends one IR packet on a modulated carrier.
//   The packet sequence is START burst, CAR_SEL burst, then one burst for each of
//   the RIGHT, LEFT, BACKWARD and FORWARD command bits. Every burst is followed by a
//   GAP of silence.
// Ports:
//   CLK     - system clock, all logic on the rising edge
//   RESET   - synchronous active-high reset
//   COMMAND - command byte (bit0 fwd, bit1 back, bit2 left, bit3 right; 7:4 unused)
//   IR_LED  - registered modulated IR drive
//   BUSY    - registered, high while a packet is in flight
module ir_transmitter #(
  parameter int unsigned CARRIER_HALF   = 1316,
  parameter int unsigned START_BURST    = 88,
  parameter int unsigned CAR_SEL_BURST  = 22,
  parameter int unsigned GAP            = 40,
  parameter int unsigned ASSERT_BURST   = 44,
  parameter int unsigned DEASSERT_BURST = 22,
  parameter int unsigned PACKET_PERIOD  = 10_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] COMMAND,
  output logic       IR_LED,
  output logic       BUSY
);

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_BURST =
    max_of(max_of(START_BURST, CAR_SEL_BURST), max_of(GAP, max_of(ASSERT_BURST, DEASSERT_BURST)));
  localparam int CW = $clog2(2 * CARRIER_HALF);
  localparam int PW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW = (PACKET_PERIOD > 1) ? $clog2(PACKET_PERIOD) : 1;

  localparam logic [CW-1:0] CAR_LAST   = CW'(2 * CARRIER_HALF - 1);
  localparam logic [CW-1:0] CAR_HALF_V = CW'(CARRIER_HALF);
  localparam logic [TW-1:0] TMR_LAST   = TW'(PACKET_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_GAP, S_CAR_SEL, S_RIGHT, S_LEFT, S_BACKWARD, S_FORWARD
  } state_t;

  state_t        state_q, state_d;
  state_t        nxt_q, nxt_d;        // where a GAP goes when it expires
  logic [3:0]    cmd_q, cmd_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] car_q, car_d;        // phase within the current carrier period
  logic [PW-1:0] per_q, per_d;        // whole carrier periods elapsed in this state
  logic          ir_led_q, ir_led_d;
  logic          busy_q, busy_d;

  logic          trigger;
  logic          sel_bit;
  logic [PW-1:0] per_last;
  state_t        follow;
  logic          burst_d;

  always_comb begin
    state_d  = state_q;
    nxt_d    = nxt_q;
    cmd_d    = cmd_q;
    car_d    = car_q;
    per_d    = per_q;
    sel_bit  = 1'b0;
    per_last = '0;
    follow   = S_IDLE;

    // The packet timer free-runs regardless of state.
    trigger = (tmr_q == TMR_LAST);
    tmr_d   = trigger ? '0 : tmr_q + TW'(1);

    case (state_q)
      S_RIGHT:    sel_bit = cmd_q[3];
      S_LEFT:     sel_bit = cmd_q[2];
      S_BACKWARD: sel_bit = cmd_q[1];
      S_FORWARD:  sel_bit = cmd_q[0];
      default:    sel_bit = 1'b0;
    endcase

    case (state_q)
      S_START:   per_last = PW'(START_BURST - 1);
      S_CAR_SEL: per_last = PW'(CAR_SEL_BURST - 1);
      S_GAP:     per_last = PW'(GAP - 1);
      S_RIGHT, S_LEFT, S_BACKWARD, S_FORWARD:
        per_last = sel_bit ? PW'(ASSERT_BURST - 1) : PW'(DEASSERT_BURST - 1);
      default:   per_last = '0;
    endcase

    case (state_q)
      S_START:    follow = S_CAR_SEL;
      S_CAR_SEL:  follow = S_RIGHT;
      S_RIGHT:    follow = S_LEFT;
      S_LEFT:     follow = S_BACKWARD;
      S_BACKWARD: follow = S_FORWARD;
      default:    follow = S_IDLE;
    endcase

    if (state_q == S_IDLE) begin
      if (trigger) begin
        state_d = S_START;
        cmd_d   = COMMAND[3:0];
        car_d   = '0;
        per_d   = '0;
      end
    end else if (car_q == CAR_LAST) begin
      car_d = '0;
      if (per_q == per_last) begin
        per_d = '0;
        if (state_q == S_GAP) begin
          state_d = nxt_q;
        end else begin
          state_d = S_GAP;
          nxt_d   = follow;
        end
      end else begin
        per_d = per_q + PW'(1);
      end
    end else begin
      car_d = car_q + CW'(1);
    end

    // Outputs are computed from next-state values so the registered
    // outputs line up with the registered state.
    burst_d  = (state_d != S_IDLE) && (state_d != S_GAP);
    ir_led_d = burst_d && (car_d < CAR_HALF_V);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      nxt_q    <= S_IDLE;
      cmd_q    <= '0;
      tmr_q    <= '0;
      car_q    <= '0;
      per_q    <= '0;
      ir_led_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nxt_q    <= nxt_d;
      cmd_q    <= cmd_d;
      tmr_q    <= tmr_d;
      car_q    <= car_d;
      per_q    <= per_d;
      ir_led_q <= ir_led_d;
      busy_q   <= busy_d;
    end
  end

  assign IR_LED = ir_led_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_ir_transmitter.sv
// tb/tb_ir_transmitter.sv - directed testbench for ir_transmitter
module tb_ir_transmitter;

  localparam int CH = 2;
  localparam int SB = 4;
  localparam int CB = 3;
  localparam int GP = 2;
  localparam int AB = 2;
  localparam int DB = 1;
  localparam int PP = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] command;
  logic       ir_led;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic wave[0:511];
  logic exp_wave[0:511];

  ir_transmitter #(
    .CARRIER_HALF(CH), .START_BURST(SB), .CAR_SEL_BURST(CB), .GAP(GP),
    .ASSERT_BURST(AB), .DEASSERT_BURST(DB), .PACKET_PERIOD(PP)
  ) dut (
    .CLK(clk), .RESET(reset), .COMMAND(command), .IR_LED(ir_led), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Builds the expected IR_LED waveform of one packet from the segment list.
  task automatic build_expected(input logic [3:0] c, output int len);
    int seg[12];
    seg = '{SB, GP, CB, GP, c[3] ? AB : DB, GP, c[2] ? AB : DB, GP,
            c[1] ? AB : DB, GP, c[0] ? AB : DB, GP};
    len = 0;
    for (int s = 0; s < 12; s++) begin
      for (int p = 0; p < seg[s] * 2 * CH; p++) begin
        exp_wave[len] = (s % 2 == 0) && ((p % (2 * CH)) < CH);
        len++;
      end
    end
  endtask

  // Waits for the next BUSY rise after BUSY is low, then records IR_LED while BUSY is high.
  task automatic capture(input int change_at, input logic [7:0] new_cmd,
                         output int len, output int edges, output int bad_pulses,
                         output int timeout);
    int n;
    int run;
    logic prev;
    timeout = 0;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) timeout = 1;
    n = 0;
    while (busy !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) timeout = 1;
    len = 0;
    while (busy === 1'b1 && len < 500) begin
      wave[len] = ir_led;
      if (len == change_at) command = new_cmd;
      len++;
      @(negedge clk);
    end
    edges = 0;
    bad_pulses = 0;
    run = 0;
    prev = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (wave[i] && !prev) edges++;
      if (wave[i]) run++;
      else if (run != 0) begin
        if (run != CH) bad_pulses++;
        run = 0;
      end
      prev = wave[i];
    end
    if (run != 0 && run != CH) bad_pulses++;
  endtask

  task automatic test_packet(input string name, input logic [7:0] cmd,
                             input int exp_len, input int exp_edges);
    int len, edges, bad, tmo, mlen, wrong;
    command = cmd;
    capture(-1, 8'h00, len, edges, bad, tmo);
    build_expected(cmd[3:0], mlen);
    vectors++;
    if (tmo !== 0) begin
      miscompares++;
      $display("FAIL %s_timeout: BUSY edge not seen within bound", name);
    end
    vectors++;
    if (len !== exp_len) begin
      miscompares++;
      $display("FAIL %s_busy_len: got %0d expected %0d", name, len, exp_len);
    end
    vectors++;
    if (edges !== exp_edges) begin
      miscompares++;
      $display("FAIL %s_edges: got %0d expected %0d", name, edges, exp_edges);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL %s_pulse_width: got %0d bad pulses expected 0", name, bad);
    end
    wrong = 0;
    for (int i = 0; i < mlen && i < 512; i++) if (wave[i] !== exp_wave[i]) wrong++;
    vectors++;
    if (wrong !== 0) begin
      miscompares++;
      $display("FAIL %s_waveform: got %0d wrong cycles expected 0", name, wrong);
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    command = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if (ir_led !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ir_led: got %b expected 0", ir_led);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    reset = 1'b0;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) break;
    end
    vectors++;
    if (n !== 200) begin
      miscompares++;
      $display("FAIL first_trigger: BUSY after %0d cycles expected 200", n);
    end
  endtask

  task automatic test_cmd_00;
    test_packet("cmd_00", 8'h00, 92, 11);
  endtask

  task automatic test_cmd_0f;
    test_packet("cmd_0f", 8'h0F, 108, 15);
  endtask

  task automatic test_cmd_f5;
    int starts[4];
    int lens[4];
    int hi, gap_hi;
    starts = '{44, 56, 72, 84};
    lens   = '{4, 8, 4, 8};
    test_packet("cmd_f5", 8'hF5, 100, 13);
    for (int k = 0; k < 4; k++) begin
      hi = 0;
      gap_hi = 0;
      for (int i = 0; i < lens[k]; i++) if (wave[starts[k] + i] === 1'b1) hi++;
      for (int i = 0; i < 8; i++) if (wave[starts[k] + lens[k] + i] === 1'b1) gap_hi++;
      vectors++;
      if (hi !== lens[k] / 2 || wave[starts[k]] !== 1'b1) begin
        miscompares++;
        $display("FAIL cmd_f5_bit%0d_burst: got %0d high cycles expected %0d", k, hi, lens[k] / 2);
      end
      vectors++;
      if (gap_hi !== 0) begin
        miscompares++;
        $display("FAIL cmd_f5_gap%0d: got %0d high cycles expected 0", k, gap_hi);
      end
    end
  endtask

  task automatic test_cmd_change;
    int len, edges, bad, tmo;
    command = 8'h00;
    capture(30, 8'h0F, len, edges, bad, tmo);
    vectors++;
    if (edges !== 11 || len !== 92 || tmo !== 0) begin
      miscompares++;
      $display("FAIL cmd_change_inflight: got edges %0d len %0d expected 11 92", edges, len);
    end
    capture(-1, 8'h00, len, edges, bad, tmo);
    vectors++;
    if (edges !== 15 || len !== 108 || tmo !== 0) begin
      miscompares++;
      $display("FAIL cmd_change_next: got edges %0d len %0d expected 15 108", edges, len);
    end
  endtask

  task automatic test_reset_mid_start;
    int n, led_hi;
    command = 8'h0F;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (busy !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (ir_led !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got led %b busy %b expected 0 0", ir_led, busy);
    end
    reset = 1'b0;
    n = 0;
    led_hi = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) break;
      if (ir_led !== 1'b0) led_hi++;
    end
    vectors++;
    if (n !== 200) begin
      miscompares++;
      $display("FAIL mid_reset_restart: BUSY after %0d cycles expected 200", n);
    end
    vectors++;
    if (led_hi !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_no_burst: got %0d led-high cycles expected 0", led_hi);
    end
  endtask

  task automatic test_back_to_back;
    int n, led_bad;
    logic seen_low;
    command = 8'h05;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (busy !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    for (int r = 0; r < 2; r++) begin
      n = 0;
      led_bad = 0;
      seen_low = 1'b0;
      while (n < 1000) begin
        @(negedge clk);
        n++;
        if (busy === 1'b0) begin
          seen_low = 1'b1;
          if (ir_led !== 1'b0) led_bad++;
        end else if (seen_low) begin
          break;
        end
      end
      vectors++;
      if (n !== 200) begin
        miscompares++;
        $display("FAIL b2b_period%0d: BUSY rises %0d cycles apart expected 200", r, n);
      end
      vectors++;
      if (led_bad !== 0) begin
        miscompares++;
        $display("FAIL b2b_idle_led%0d: got %0d led-high idle cycles expected 0", r, led_bad);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    command = 8'h00;
    test_reset();
    test_cmd_00();
    test_cmd_0f();
    test_cmd_f5();
    test_cmd_change();
    test_reset_mid_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
